// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface ram_arbiter_if;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WORD_W = 8;

   logic              req0;
   logic              req1;
   logic              wr0;
   logic              wr1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [WORD_W-1:0] wdata0;
   logic [WORD_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic [WORD_W-1:0] rdata0;
   logic [WORD_W-1:0] rdata1;
   logic [ADDR_W-1:0] ram_addr;
   logic [WORD_W-1:0] ram_data_in;
   logic              ram_wr;
   logic              ram_cs;
   logic [WORD_W-1:0] ram_data_out;

   // Environment side: requesters plus the RAM read port
   modport master (
      output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_data_out,
      input  gnt0, gnt1, rdata0, rdata1, ram_addr, ram_data_in, ram_wr, ram_cs
   );

   // Arbiter side
   modport slave (
      input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, ram_data_out,
      output gnt0, gnt1, rdata0, rdata1, ram_addr, ram_data_in, ram_wr, ram_cs
   );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing a single-port RAM; each access
// runs IDLE -> ACCESS -> DONE with every RAM-side output and grant taken from a flop.
module ram_arbiter (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus_io
);
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned WORD_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              sel_q, sel_d;
   logic              wr_q, wr_d;
   logic              ptr_q, ptr_d;
   logic              ram_wr_q, ram_wr_d;
   logic              ram_cs_q, ram_cs_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [WORD_W-1:0] ram_data_in_q, ram_data_in_d;
   logic [WORD_W-1:0] rdata0_q, rdata0_d;
   logic [WORD_W-1:0] rdata1_q, rdata1_d;
   logic              any_req;
   logic              pick;

   assign any_req = bus_io.req0 | bus_io.req1;
   // On a tie the requester not granted last wins; ptr_q holds the last grantee
   assign pick    = (bus_io.req0 & bus_io.req1) ? ~ptr_q : bus_io.req1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = ACCESS;
         ACCESS:  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; address/data hold until the next selection
   always_comb begin
      sel_d         = sel_q;
      wr_d          = wr_q;
      ptr_d         = ptr_q;
      ram_addr_d    = ram_addr_q;
      ram_data_in_d = ram_data_in_q;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      ram_wr_d      = 1'b0;
      ram_cs_d      = 1'b0;
      gnt0_d        = 1'b0;
      gnt1_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               sel_d         = pick;
               wr_d          = pick ? bus_io.wr1    : bus_io.wr0;
               ram_addr_d    = pick ? bus_io.addr1  : bus_io.addr0;
               ram_data_in_d = pick ? bus_io.wdata1 : bus_io.wdata0;
               ram_cs_d      = 1'b1;
               ram_wr_d      = wr_d;
            end
         end
         ACCESS: begin
            ptr_d  = sel_q;
            gnt0_d = ~sel_q;
            gnt1_d = sel_q;
            if (!wr_q) begin
               if (sel_q) rdata1_d = bus_io.ram_data_out;
               else       rdata0_d = bus_io.ram_data_out;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q         <= 1'b0;
         wr_q          <= 1'b0;
         ptr_q         <= 1'b1;
         ram_wr_q      <= 1'b0;
         ram_cs_q      <= 1'b0;
         gnt0_q        <= 1'b0;
         gnt1_q        <= 1'b0;
         ram_addr_q    <= '0;
         ram_data_in_q <= '0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
      end else begin
         sel_q         <= sel_d;
         wr_q          <= wr_d;
         ptr_q         <= ptr_d;
         ram_wr_q      <= ram_wr_d;
         ram_cs_q      <= ram_cs_d;
         gnt0_q        <= gnt0_d;
         gnt1_q        <= gnt1_d;
         ram_addr_q    <= ram_addr_d;
         ram_data_in_q <= ram_data_in_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
      end
   end

   assign bus_io.gnt0        = gnt0_q;
   assign bus_io.gnt1        = gnt1_q;
   assign bus_io.rdata0      = rdata0_q;
   assign bus_io.rdata1      = rdata1_q;
   assign bus_io.ram_addr    = ram_addr_q;
   assign bus_io.ram_data_in = ram_data_in_q;
   assign bus_io.ram_wr      = ram_wr_q;
   assign bus_io.ram_cs      = ram_cs_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, randomized traffic against a
// transaction-level model, and hand-written fairness / reset-abort sequences.
module tb_ram_arbiter;
   logic clk = 1'b0;
   logic rst;

   ram_arbiter_if bus ();

   ram_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // RAM model: async read, write while cs & wr; unwritten words read a fixed pattern
   logic [7:0] mem [1024];
   logic       wv  [1024];

   function automatic logic [7:0] init_val(input logic [9:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   always @(posedge clk) begin
      if (bus.ram_cs === 1'b1 && bus.ram_wr === 1'b1) begin
         mem[bus.ram_addr] <= bus.ram_data_in;
         wv[bus.ram_addr]  <= 1'b1;
      end
   end

   assign bus.ram_data_out = (wv[bus.ram_addr] === 1'b1) ? mem[bus.ram_addr]
                                                          : init_val(bus.ram_addr);

   int n_tot  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, act, exp);
   endtask

   logic       r_req [2];
   logic       r_wr  [2];
   logic [9:0] r_addr[2];
   logic [7:0] r_wd  [2];

   task automatic drive();
      bus.req0   = r_req[0];  bus.req1   = r_req[1];
      bus.wr0    = r_wr[0];   bus.wr1    = r_wr[1];
      bus.addr0  = r_addr[0]; bus.addr1  = r_addr[1];
      bus.wdata0 = r_wd[0];   bus.wdata1 = r_wd[1];
   endtask

   logic       prev_wr   = 1'b0;
   logic [9:0] prev_addr = '0;
   logic [7:0] prev_din  = '0;

   // Advance to the next falling edge and check RAM-side sequencing rules
   task automatic tick();
      @(negedge clk);
      if (prev_wr && !bus.ram_wr && !rst) begin
         chk("addr_hold_at_wr_fall", 32'(bus.ram_addr), 32'(prev_addr));
         chk("din_hold_at_wr_fall", 32'(bus.ram_data_in), 32'(prev_din));
      end
      if (bus.ram_wr) chk("wr_implies_cs", 32'(bus.ram_cs), 32'd1);
      prev_wr   = bus.ram_wr;
      prev_addr = bus.ram_addr;
      prev_din  = bus.ram_data_in;
   endtask

   typedef struct {
      logic       rst;
      logic       r0; logic w0; logic [9:0] a0; logic [7:0] d0;
      logic       r1; logic w1; logic [9:0] a1; logic [7:0] d1;
      logic       g0; logic g1; logic cs; logic wr;
      logic [9:0] ra; logic [7:0] rdi; logic [7:0] rd0; logic [7:0] rd1;
   } vec_t;

   vec_t vt[19];

   logic [7:0] shadow [1024];
   int         busy;
   int         cur;
   logic       last_m;
   logic       exp_g  [2];
   logic [7:0] exp_rd [2];
   logic       exp_cs, exp_wr;
   logic [9:0] exp_ra;
   logic [7:0] exp_din;
   int         gq[$];
   logic       first;

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(10'(i));

      //             rst r0 w0 a0      d0     r1 w1 a1      d1     g0 g1 cs wr ra      rdi    rd0    rd1
      vt[0]  = '{1'b1, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 10'h000, 8'h00, 8'h00, 8'h00};
      vt[1]  = '{1'b0, 1, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 0, 1, 0, 10'h001, 8'h00, 8'h00, 8'h00};
      vt[2]  = '{1'b0, 1, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 1, 0, 0, 0, 10'h001, 8'h00, 8'h5B, 8'h00};
      vt[3]  = '{1'b0, 0, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 0, 0, 0, 10'h001, 8'h00, 8'h5B, 8'h00};
      vt[4]  = '{1'b0, 0, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 0, 1, 0, 10'h3FF, 8'h00, 8'h5B, 8'h00};
      vt[5]  = '{1'b0, 0, 0, 10'h001, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 1, 0, 0, 10'h3FF, 8'h00, 8'h5B, 8'hA5};
      vt[6]  = '{1'b0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 10'h3FF, 8'h00, 8'h5B, 8'hA5};
      vt[7]  = '{1'b0, 1, 1, 10'h155, 8'hA5, 0, 0, 10'h000, 8'h00, 0, 0, 1, 1, 10'h155, 8'hA5, 8'h5B, 8'hA5};
      vt[8]  = '{1'b0, 1, 1, 10'h155, 8'hA5, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 10'h155, 8'hA5, 8'h5B, 8'hA5};
      vt[9]  = '{1'b0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 10'h155, 8'hA5, 8'h5B, 8'hA5};
      vt[10] = '{1'b0, 1, 0, 10'h155, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 1, 0, 10'h155, 8'h00, 8'h5B, 8'hA5};
      vt[11] = '{1'b0, 1, 0, 10'h155, 8'h00, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 10'h155, 8'h00, 8'hA5, 8'hA5};
      vt[12] = '{1'b0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 10'h155, 8'h00, 8'hA5, 8'hA5};
      vt[13] = '{1'b0, 1, 1, 10'h010, 8'h3C, 0, 0, 10'h000, 8'h00, 0, 0, 1, 1, 10'h010, 8'h3C, 8'hA5, 8'hA5};
      vt[14] = '{1'b0, 1, 1, 10'h010, 8'h3C, 0, 0, 10'h000, 8'h00, 1, 0, 0, 0, 10'h010, 8'h3C, 8'hA5, 8'hA5};
      vt[15] = '{1'b0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h3F0, 8'h00, 0, 0, 0, 0, 10'h010, 8'h3C, 8'hA5, 8'hA5};
      vt[16] = '{1'b0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h3F0, 8'h00, 0, 0, 1, 0, 10'h3F0, 8'h00, 8'hA5, 8'hA5};
      vt[17] = '{1'b0, 0, 0, 10'h000, 8'h00, 1, 0, 10'h3F0, 8'h00, 0, 1, 0, 0, 10'h3F0, 8'h00, 8'hA5, 8'hAA};
      vt[18] = '{1'b0, 0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 0, 0, 0, 10'h3F0, 8'h00, 8'hA5, 8'hAA};

      // Reset, then ten idle cycles with no RAM activity
      rst = 1'b1;
      for (int r = 0; r < 2; r++) begin
         r_req[r] = 1'b0; r_wr[r] = 1'b0; r_addr[r] = '0; r_wd[r] = '0;
      end
      drive();
      repeat (2) tick();
      chk("reset_gnt0", 32'(bus.gnt0), 32'd0);
      chk("reset_gnt1", 32'(bus.gnt1), 32'd0);
      chk("reset_cs", 32'(bus.ram_cs), 32'd0);
      chk("reset_wr", 32'(bus.ram_wr), 32'd0);
      chk("reset_addr", 32'(bus.ram_addr), 32'd0);
      chk("reset_din", 32'(bus.ram_data_in), 32'd0);
      chk("reset_rdata0", 32'(bus.rdata0), 32'd0);
      chk("reset_rdata1", 32'(bus.rdata1), 32'd0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("idle_cs", 32'(bus.ram_cs), 32'd0);
         chk("idle_wr", 32'(bus.ram_wr), 32'd0);
      end

      // Directed cycle-by-cycle vectors
      for (int i = 0; i < 19; i++) begin
         rst = vt[i].rst;
         r_req[0] = vt[i].r0; r_wr[0] = vt[i].w0; r_addr[0] = vt[i].a0; r_wd[0] = vt[i].d0;
         r_req[1] = vt[i].r1; r_wr[1] = vt[i].w1; r_addr[1] = vt[i].a1; r_wd[1] = vt[i].d1;
         drive();
         tick();
         chk($sformatf("vec%0d_gnt0", i), 32'(bus.gnt0), 32'(vt[i].g0));
         chk($sformatf("vec%0d_gnt1", i), 32'(bus.gnt1), 32'(vt[i].g1));
         chk($sformatf("vec%0d_cs", i), 32'(bus.ram_cs), 32'(vt[i].cs));
         chk($sformatf("vec%0d_wr", i), 32'(bus.ram_wr), 32'(vt[i].wr));
         chk($sformatf("vec%0d_addr", i), 32'(bus.ram_addr), 32'(vt[i].ra));
         chk($sformatf("vec%0d_din", i), 32'(bus.ram_data_in), 32'(vt[i].rdi));
         chk($sformatf("vec%0d_rdata0", i), 32'(bus.rdata0), 32'(vt[i].rd0));
         chk($sformatf("vec%0d_rdata1", i), 32'(bus.rdata1), 32'(vt[i].rd1));
      end
      shadow[10'h155] = 8'hA5;
      shadow[10'h010] = 8'h3C;

      // Randomized traffic against a transaction-level model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      busy = 0; cur = 0; last_m = 1'b1;
      exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
      exp_cs = 1'b0; exp_wr = 1'b0; exp_ra = '0; exp_din = '0;
      for (int c = 0; c < 600; c++) begin
         tick();
         chk("rnd_gnt0", 32'(bus.gnt0), 32'(exp_g[0]));
         chk("rnd_gnt1", 32'(bus.gnt1), 32'(exp_g[1]));
         chk("rnd_cs", 32'(bus.ram_cs), 32'(exp_cs));
         chk("rnd_wr", 32'(bus.ram_wr), 32'(exp_wr));
         chk("rnd_addr", 32'(bus.ram_addr), 32'(exp_ra));
         chk("rnd_din", 32'(bus.ram_data_in), 32'(exp_din));
         if (exp_g[0]) chk("rnd_rdata0", 32'(bus.rdata0), 32'(exp_rd[0]));
         if (exp_g[1]) chk("rnd_rdata1", 32'(bus.rdata1), 32'(exp_rd[1]));
         for (int r = 0; r < 2; r++) begin
            if (r_req[r] && exp_g[r]) begin
               r_req[r] = 1'b0;
            end else if (!r_req[r] && $urandom_range(0, 2) == 0) begin
               r_req[r]  = 1'b1;
               r_wr[r]   = 1'($urandom_range(0, 1));
               r_addr[r] = 10'($urandom_range(0, 15));
               r_wd[r]   = 8'($urandom);
            end
         end
         drive();
         exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_cs = 1'b0; exp_wr = 1'b0;
         if (busy > 0) begin
            busy = busy - 1;
            if (busy == 1) exp_g[cur] = 1'b1;
         end else if (r_req[0] || r_req[1]) begin
            cur     = (r_req[0] && r_req[1]) ? (last_m ? 0 : 1) : (r_req[1] ? 1 : 0);
            last_m  = (cur == 1);
            busy    = 2;
            exp_cs  = 1'b1;
            exp_wr  = r_wr[cur];
            exp_ra  = r_addr[cur];
            exp_din = r_wd[cur];
            if (r_wr[cur]) shadow[r_addr[cur]] = r_wd[cur];
            else           exp_rd[cur] = shadow[r_addr[cur]];
         end
      end

      // Fairness: both requesters hold a read request continuously
      r_req[0] = 1'b0; r_req[1] = 1'b0;
      drive();
      repeat (4) tick();
      first = ~last_m;
      r_req[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 10'h020;
      r_req[1] = 1'b1; r_wr[1] = 1'b0; r_addr[1] = 10'h021;
      drive();
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.gnt0) gq.push_back(0);
         if (bus.gnt1) gq.push_back(1);
      end
      chk("fair_grant_count", 32'(gq.size()), 32'd4);
      for (int i = 0; i < gq.size(); i++)
         chk($sformatf("fair_grant%0d", i), 32'(gq[i]), 32'(first ^ 1'(i)));
      r_req[0] = 1'b0; r_req[1] = 1'b0;
      drive();
      repeat (4) tick();

      // Requester 0 granted last, then reset aborts requester 1's read mid-ACCESS
      r_req[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 10'h005;
      drive();
      tick();
      tick();
      chk("pre_abort_gnt0", 32'(bus.gnt0), 32'd1);
      r_req[0] = 1'b0;
      drive();
      tick();
      r_req[1] = 1'b1; r_wr[1] = 1'b0; r_addr[1] = 10'h006;
      drive();
      tick();
      chk("abort_in_access_cs", 32'(bus.ram_cs), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_cs", 32'(bus.ram_cs), 32'd0);
      chk("abort_wr", 32'(bus.ram_wr), 32'd0);
      chk("abort_gnt0", 32'(bus.gnt0), 32'd0);
      chk("abort_gnt1", 32'(bus.gnt1), 32'd0);
      chk("abort_addr", 32'(bus.ram_addr), 32'd0);
      chk("abort_din", 32'(bus.ram_data_in), 32'd0);
      chk("abort_rdata0", 32'(bus.rdata0), 32'd0);
      chk("abort_rdata1", 32'(bus.rdata1), 32'd0);
      tick();
      r_req[1] = 1'b0;
      drive();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("post_abort_no_gnt1", 32'(bus.gnt1), 32'd0);
         chk("post_abort_no_gnt0", 32'(bus.gnt0), 32'd0);
      end

      // Tie after reset: requester 0 must win first
      r_req[0] = 1'b1; r_wr[0] = 1'b0; r_addr[0] = 10'h007;
      r_req[1] = 1'b1; r_wr[1] = 1'b0; r_addr[1] = 10'h008;
      drive();
      tick();
      tick();
      chk("tie_gnt0", 32'(bus.gnt0), 32'd1);
      chk("tie_gnt1_low", 32'(bus.gnt1), 32'd0);
      chk("tie_rdata0", 32'(bus.rdata0), 32'(shadow[10'h007]));
      r_req[0] = 1'b0;
      drive();
      tick();
      tick();
      tick();
      chk("tie_gnt1", 32'(bus.gnt1), 32'd1);
      chk("tie_rdata1", 32'(bus.rdata1), 32'(shadow[10'h008]));
      r_req[1] = 1'b0;
      drive();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
